mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Byte-serial memory sequencer between the MAR/MDR/control-unit datapath and the 256x8 byte-wide RAM.
- Accepts one byte, halfword or word load/store request.
- Runs the MOV/MOC handshake once per byte and assembles or splits the data big-endian.
- Returns a 32-bit result with done/err status, so the control unit no longer sequences RAM bytes itself.

Parameters:
- ADDR_W, 8, RAM address width; memory depth is 2**ADDR_W bytes.
- TIMEOUT, 15, maximum cycles spent waiting in one handshake phase before the access aborts.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous active-high reset.
- req  in  1  start request; sampled only in IDLE.
- rw  in  1  1 = read (load), 0 = write (store).
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- sx  in  1  sign-extend byte/halfword reads (1) or zero-extend (0).
- addr  in  32  byte address (from MAR).
- wdata  in  32  store data (from MDR).
- rdata  out  32  load result.
- busy  out  1  high from the accept edge until the edge that leaves DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  status of the last access; valid with done, held until the next accept.
- mem_addr  out  ADDR_W  RAM byte address.
- mem_wdata  out  8  RAM write byte.
- mem_rdata  in  8  RAM read byte.
- mem_rw  out  1  RAM direction; mirrors latched rw.
- mem_mov  out  1  memory operation valid.
- mem_moc  in  1  memory operation complete.

Behaviour:
- Reset (async, CLR=1): state IDLE; rdata=0, busy=0, done=0, err=0, mem_mov=0, mem_rw=1, mem_addr=0, mem_wdata=0, byte counter=0, timeout counter=0.
- CLR mid-access drops mem_mov immediately and abandons the access; no partial result is reported.
- Accept:
  - In IDLE with req=1, latch rw, size, sx, addr and wdata; clear rdata and err.
  - Legal: go to ISSUE.
  - Illegal: go directly to DONE with err=1 and no RAM cycle.
- Illegal requests:
  - size=11;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:ADDR_W] nonzero.
- Because legal accesses are aligned and in range, byte addresses never wrap.
- req while busy is ignored and not queued.
- Byte count N = 1, 2 or 4 for byte, halfword or word. Counter k runs 0..N-1; mem_addr = addr[ADDR_W-1:0] + k.
- Big-endian lane mapping:
  - byte at addr+0 is the most significant byte of the access;
  - word write bytes: wdata[31:24], [23:16], [15:8], [7:0];
  - halfword write bytes: wdata[15:8], [7:0];
  - byte write: wdata[7:0].
- ISSUE:
  - mem_mov=1; mem_addr and mem_wdata valid.
  - When mem_moc=1: on a read, capture mem_rdata into lane k; go to RELEASE.
- RELEASE:
  - mem_mov=0.
  - When mem_moc=0: if k==N-1 go to DONE, else k=k+1 and go to ISSUE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - For reads, rdata is final during DONE and held until the next accept.
  - Byte/halfword results are sign-extended from bit 7/15 when sx=1, zero-extended when sx=0.
  - Writes leave rdata=0.
- Timeout:
  - The timeout counter resets on every ISSUE/RELEASE entry.
  - If the counter reaches TIMEOUT cycles without the awaited mem_moc level, go to DONE with err=1 and mem_mov=0.
  - Bytes already written stay written.
- Outputs mem_mov, mem_addr, mem_wdata and mem_rw are decoded from registered state only, with no combinational path from mem_moc.
- Latency with a RAM that raises and drops MOC one cycle after MOV rises and falls: 4 cycles per byte. Measured from the accept edge (cycle 0), done is high in cycle 4N+1.

Test Plan:
- Word read, RAM[4..7]=DE AD BE EF, addr=4, size=10 -> four MOV/MOC pairs at mem_addr 4,5,6,7; done in cycle 17; rdata=0xDEADBEEF; err=0.
- Byte read, RAM[9]=0x80, size=00, sx=1 then sx=0 -> rdata=0xFFFFFF80 then 0x00000080; done in cycle 5.
- Halfword write, wdata=0x1234ABCD, addr=2, size=01 -> RAM[2]=0xAB, RAM[3]=0xCD; RAM[1] and RAM[4] unchanged; mem_rw=0 throughout.
- Misaligned word, addr=6 -> done in cycle 1 with err=1; mem_mov never asserted. Then addr=0x100 -> err=1; then size=11 -> err=1.
- RAM never raises MOC on a word read -> mem_mov high 15 cycles, then done with err=1 and mem_mov=0. A new req is accepted afterwards.
- CLR pulsed during the third byte of a word write with mem_mov=1 -> mem_mov, busy and done go 0 immediately. req=1 asserted during busy before the CLR is ignored, and no transfer follows once CLR releases until a fresh req.

Source files
------------

// File: rtl/mem_access_unit.sv
// Byte-serial RAM sequencer: one byte/halfword/word access at a time, split into
// big-endian byte transfers over the MOV/MOC handshake.
module mem_access_unit #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              req,
   input  logic              rw,
   input  logic [1:0]        size,
   input  logic              sx,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              mem_rw,
   output logic              mem_mov,
   input  logic              mem_moc
);

   // state     | meaning
   // S_IDLE    | waiting for req
   // S_ISSUE   | MOV high, waiting for MOC high
   // S_RELEASE | MOV low, waiting for MOC low
   // S_DONE    | one-cycle completion pulse
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_DONE} state_t;

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t            r_state, w_state_nx;
   logic              r_rw, r_sx, r_err;
   logic [1:0]        r_nm1, r_k;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata, r_rdata;
   logic [TW-1:0]     r_tmo;

   logic       w_illegal, w_accept, w_capture, w_k_inc, w_extend;
   logic       w_tmo_load, w_tmo_dec, w_tmo_err;
   logic [1:0] w_lane;
   logic [4:0] w_bit;

   assign w_illegal = (size == 2'b11)
                    || (size == 2'b01 && addr[0])
                    || (size == 2'b10 && addr[1:0] != 2'b00)
                    || ((addr >> ADDR_W) != 32'd0);

   // Byte k of the access lands in lane N-1-k (big-endian).
   assign w_lane = r_nm1 - r_k;
   assign w_bit  = {w_lane, 3'b000};

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_accept   = 1'b0;
      w_capture  = 1'b0;
      w_k_inc    = 1'b0;
      w_extend   = 1'b0;
      w_tmo_load = 1'b0;
      w_tmo_dec  = 1'b0;
      w_tmo_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_accept   = 1'b1;
               w_tmo_load = 1'b1;
               w_state_nx = w_illegal ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (mem_moc) begin
               w_capture  = r_rw;
               w_tmo_load = 1'b1;
               w_state_nx = S_RELEASE;
            end else if (r_tmo == '0) begin
               w_tmo_err  = 1'b1;
               w_state_nx = S_DONE;
            end else begin
               w_tmo_dec = 1'b1;
            end
         end
         S_RELEASE: begin
            if (!mem_moc) begin
               if (r_k == r_nm1) begin
                  w_extend   = r_rw;
                  w_state_nx = S_DONE;
               end else begin
                  w_k_inc    = 1'b1;
                  w_tmo_load = 1'b1;
                  w_state_nx = S_ISSUE;
               end
            end else if (r_tmo == '0) begin
               w_tmo_err  = 1'b1;
               w_state_nx = S_DONE;
            end else begin
               w_tmo_dec = 1'b1;
            end
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_rw    <= 1'b1;
         r_sx    <= 1'b0;
         r_err   <= 1'b0;
         r_nm1   <= 2'd0;
         r_k     <= 2'd0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_tmo   <= '0;
      end else begin
         if (w_accept) begin
            r_rw    <= rw;
            r_sx    <= sx;
            r_addr  <= addr[ADDR_W-1:0];
            r_wdata <= wdata;
            r_nm1   <= (size == 2'b00) ? 2'd0 : (size == 2'b01) ? 2'd1 : 2'd3;
            r_k     <= 2'd0;
            r_rdata <= 32'd0;
            r_err   <= w_illegal;
         end
         if (w_tmo_load)     r_tmo <= TW'(TIMEOUT - 1);
         else if (w_tmo_dec) r_tmo <= r_tmo - 1'b1;
         if (w_capture) r_rdata[w_bit +: 8] <= mem_rdata;
         if (w_k_inc)   r_k <= r_k + 2'd1;
         if (w_tmo_err) r_err <= 1'b1;
         // Low lanes are complete when the last byte releases; fill the upper bits.
         if (w_extend) begin
            case (r_nm1)
               2'd0:    r_rdata[31:8]  <= {24{r_sx & r_rdata[7]}};
               2'd1:    r_rdata[31:16] <= {16{r_sx & r_rdata[15]}};
               default: ;
            endcase
         end
      end
   end

   assign rdata     = r_rdata;
   assign err       = r_err;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign mem_mov   = (r_state == S_ISSUE);
   assign mem_rw    = r_rw;
   assign mem_addr  = r_addr + {{(ADDR_W-2){1'b0}}, r_k};
   assign mem_wdata = r_wdata[w_bit +: 8];

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of accesses against a MOV/MOC RAM model,
// with a scoreboard queue checked at each done pulse, plus timeout and CLR sequences.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        CLR, req, rw, sx;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata;
   logic        busy, done, err;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic        mem_rw, mem_mov, mem_moc;

   logic [7:0]  mem [0:255];
   logic        tb_init, ram_stall;
   int          cyc = 0;
   int          n_total = 0, n_pass = 0;
   int          k_seen = 0, mov_cnt = 0;
   logic        prev_mov = 1'b0;

   typedef struct {
      logic        rw;
      logic [1:0]  size;
      logic        sx;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_movc;
   } vec_t;

   typedef struct {
      vec_t v;
      int   acc;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb[$];

   mem_access_unit #(.ADDR_W(8), .TIMEOUT(15)) dut (
      .CLK(CLK), .CLR(CLR), .req(req), .rw(rw), .size(size), .sx(sx),
      .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
      .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rw(mem_rw), .mem_mov(mem_mov),
      .mem_moc(mem_moc)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // RAM: MOC follows MOV one cycle later; a write lands on the edge that raises MOC.
   assign mem_rdata = mem[mem_addr];
   always @(posedge CLK) begin
      if (tb_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
         mem[4]  <= 8'hDE; mem[5]  <= 8'hAD; mem[6] <= 8'hBE; mem[7] <= 8'hEF;
         mem[9]  <= 8'h80; mem[16] <= 8'h9A; mem[17] <= 8'h3C; mem[20] <= 8'h7F;
         mem_moc <= 1'b0;
      end else begin
         mem_moc <= ram_stall ? 1'b0 : mem_mov;
         if (mem_mov && !mem_moc && !mem_rw) mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   // Scoreboard consumer: address/data per byte, result at done.
   always @(negedge CLK) begin
      if (CLR) begin
         k_seen   = 0;
         mov_cnt  = 0;
         prev_mov = 1'b0;
      end else begin
         if (mem_mov) begin
            mov_cnt++;
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL mov_idle: mem_mov=1 with no access outstanding at cycle %0d", cyc);
            end else if (!prev_mov) begin
               int n, lane;
               logic [31:0] ew;
               n    = (sb[0].v.size == 2'b00) ? 1 : (sb[0].v.size == 2'b01) ? 2 : 4;
               lane = n - 1 - k_seen;
               ew   = sb[0].v.wdata >> (8 * lane);
               chk("mem_addr", {24'd0, mem_addr}, {24'd0, 8'(sb[0].v.addr[7:0] + 8'(k_seen))});
               chk("mem_rw", {31'd0, mem_rw}, {31'd0, sb[0].v.rw});
               if (!sb[0].v.rw) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, ew[7:0]});
               k_seen++;
            end
         end
         prev_mov = mem_mov;
         if (done) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL done_idle: done=1 with no access outstanding at cycle %0d", cyc);
            end else begin
               sb_t e;
               e = sb.pop_front();
               chk("rdata", rdata, e.v.exp_rdata);
               chk("err", {31'd0, err}, {31'd0, e.v.exp_err});
               chk("latency", 32'(cyc - e.acc + 1), 32'(e.v.exp_lat));
               chk("mov_cycles", 32'(mov_cnt), 32'(e.v.exp_movc));
               chk("mov_at_done", {31'd0, mem_mov}, 32'd0);
               chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
            k_seen  = 0;
            mov_cnt = 0;
         end
      end
   end

   task automatic run_op(input vec_t v);
      @(negedge CLK);
      rw = v.rw; size = v.size; sx = v.sx; addr = v.addr; wdata = v.wdata; req = 1'b1;
      @(posedge CLK);
      #1;
      sb.push_back('{v, cyc});
      req = 1'b0;
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL op_timeout: no done within 100 cycles for addr %h", v.addr);
         sb.delete();
      end
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      CLR = 1'b1; req = 1'b0; rw = 1'b1; size = 2'b00; sx = 1'b0;
      addr = 32'd0; wdata = 32'd0; tb_init = 1'b1; ram_stall = 1'b0;

      //      rw sz    sx addr        wdata         exp_rdata     err lat mov
      tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h04,  32'h0,        32'hDEADBEEF, 1'b0, 17, 8});
      tbl.push_back('{1'b1, 2'b00, 1'b1, 32'h09,  32'h0,        32'hFFFFFF80, 1'b0, 5,  2});
      tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h09,  32'h0,        32'h00000080, 1'b0, 5,  2});
      tbl.push_back('{1'b1, 2'b01, 1'b1, 32'h10,  32'h0,        32'hFFFF9A3C, 1'b0, 9,  4});
      tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h10,  32'h0,        32'h00009A3C, 1'b0, 9,  4});
      tbl.push_back('{1'b1, 2'b00, 1'b1, 32'h14,  32'h0,        32'h0000007F, 1'b0, 5,  2});
      tbl.push_back('{1'b0, 2'b01, 1'b0, 32'h02,  32'h1234ABCD, 32'h0,        1'b0, 9,  4});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 32'h20,  32'hCAFEF00D, 32'h0,        1'b0, 17, 8});
      tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h20,  32'h0,        32'hCAFEF00D, 1'b0, 17, 8});
      tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h25,  32'hFFFFFFA5, 32'h0,        1'b0, 5,  2});
      tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h25,  32'h0,        32'h000000A5, 1'b0, 5,  2});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 32'hFC,  32'h0BADF00D, 32'h0,        1'b0, 17, 8});
      tbl.push_back('{1'b1, 2'b00, 1'b1, 32'hFF,  32'h0,        32'h0000000D, 1'b0, 5,  2});
      tbl.push_back('{1'b1, 2'b01, 1'b1, 32'hFE,  32'h0,        32'hFFFFF00D, 1'b0, 9,  4});
      tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h06,  32'h0,        32'h0,        1'b1, 1,  0});
      tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 1,  0});
      tbl.push_back('{1'b1, 2'b11, 1'b0, 32'h00,  32'h0,        32'h0,        1'b1, 1,  0});
      tbl.push_back('{1'b1, 2'b01, 1'b0, 32'h03,  32'h0,        32'h0,        1'b1, 1,  0});
      tbl.push_back('{1'b0, 2'b00, 1'b0, 32'h100, 32'h55,       32'h0,        1'b1, 1,  0});

      repeat (3) @(posedge CLK);
      tb_init = 1'b0;
      @(negedge CLK);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_mov", {31'd0, mem_mov}, 32'd0);
      chk("rst_rw", {31'd0, mem_rw}, 32'd1);
      chk("rst_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
      CLR = 1'b0;
      repeat (2) @(negedge CLK);

      foreach (tbl[i]) run_op(tbl[i]);

      chk("err_held", {31'd0, err}, 32'd1);
      chk("ram1_kept", {24'd0, mem[1]}, 32'h0A);
      chk("ram2_hw", {24'd0, mem[2]}, 32'hAB);
      chk("ram3_hw", {24'd0, mem[3]}, 32'hCD);
      chk("ram4_kept", {24'd0, mem[4]}, 32'hDE);

      // RAM never answers: 15 cycles of MOV, then error.
      ram_stall = 1'b1;
      run_op('{1'b1, 2'b10, 1'b0, 32'h04, 32'h0, 32'h0, 1'b1, 16, 15});
      ram_stall = 1'b0;
      run_op('{1'b1, 2'b00, 1'b0, 32'h09, 32'h0, 32'h00000080, 1'b0, 5, 2});

      // CLR during third byte of a word write, with an ignored req pending.
      @(negedge CLK);
      rw = 1'b0; size = 2'b10; sx = 1'b0; addr = 32'h40; wdata = 32'h11223344; req = 1'b1;
      @(posedge CLK);
      #1;
      sb.push_back('{'{1'b0, 2'b10, 1'b0, 32'h40, 32'h11223344, 32'h0, 1'b0, 17, 8}, cyc});
      req = 1'b0;
      repeat (3) @(negedge CLK);
      rw = 1'b1; size = 2'b00; addr = 32'h09; req = 1'b1;
      repeat (6) @(negedge CLK);
      chk("clr_pre_mov", {31'd0, mem_mov}, 32'd1);
      chk("clr_pre_addr", {24'd0, mem_addr}, 32'h42);
      CLR = 1'b1;
      #1;
      chk("clr_mov", {31'd0, mem_mov}, 32'd0);
      chk("clr_busy", {31'd0, busy}, 32'd0);
      chk("clr_done", {31'd0, done}, 32'd0);
      sb.delete();
      req = 1'b0;
      @(negedge CLK);
      CLR = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk("post_clr_mov", {31'd0, mem_mov}, 32'd0);
         chk("post_clr_busy", {31'd0, busy}, 32'd0);
      end
      chk("post_clr_rdata", rdata, 32'd0);
      chk("ram40", {24'd0, mem[8'h40]}, 32'h11);
      chk("ram41", {24'd0, mem[8'h41]}, 32'h22);
      chk("ram42_kept", {24'd0, mem[8'h42]}, 32'hD1);
      chk("ram43_kept", {24'd0, mem[8'h43]}, 32'hD8);
      run_op('{1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1122D1D8, 1'b0, 17, 8});

      repeat (3) @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
